// File: rtl/rv32i_pkg.sv
// rv32i_pkg
//   Shared constants and types for the RV32I writeback path.
//   XLEN               : register data width
//   REG_ADDR_W         : register-file address width
//   NUM_REGS           : number of architectural registers
//   STARVE_MAX_DEFAULT : default ALU starvation limit for the writeback arbiter
//   STARVE_W           : width of the starvation counter (covers limits 1..15)
package rv32i_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned REG_ADDR_W         = 5;
    localparam int unsigned NUM_REGS           = 32;
    localparam int unsigned STARVE_MAX_DEFAULT = 3;
    localparam int unsigned STARVE_W           = 4;

    // One writeback request: destination register plus data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // x0 is hardwired to zero: writes to it are discarded, never tracked.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/rv32i_wb_scoreboard.sv
// rv32i_wb_scoreboard
//   Tracks registers with an outstanding writeback (one bit per register).
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_issue, i_issue_addr   : decode issued an instruction writing this register
//   i_wr, i_wr_addr         : register-file write happening this cycle
//   i_chk_addr1/2           : source registers being decoded
//   o_busy1/2               : source still has a pending write
module rv32i_wb_scoreboard
    import rv32i_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_issue,
    input  logic [REG_ADDR_W-1:0] i_issue_addr,
    input  logic                  i_wr,
    input  logic [REG_ADDR_W-1:0] i_wr_addr,
    input  logic [REG_ADDR_W-1:0] i_chk_addr1,
    input  logic [REG_ADDR_W-1:0] i_chk_addr2,
    output logic                  o_busy1,
    output logic                  o_busy2
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Set takes precedence over clear so a re-issue racing the previous
    // writeback of the same register stays marked busy.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (i_issue && i_issue_addr == REG_ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end else if (i_wr && i_wr_addr == REG_ADDR_W'(i)) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // The register file captures its read address on the same edge it
    // writes, so a write in flight this cycle already satisfies the reader.
    always_comb begin
        o_busy1 = busy_q[i_chk_addr1] && !(i_wr && i_wr_addr == i_chk_addr1);
        o_busy2 = busy_q[i_chk_addr2] && !(i_wr && i_wr_addr == i_chk_addr2);
    end

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// rv32i_wb_arbiter
//   Arbitrates ALU and load writebacks onto the single register-file write
//   port and hosts the register scoreboard.
//   i_clk, i_rst                          : clock, synchronous active-high reset
//   i_alu_valid/o_alu_ready/_rd_addr/_rd  : ALU writeback handshake
//   i_mem_valid/o_mem_ready/_rd_addr/_rd  : load writeback handshake
//   i_issue, i_issue_addr                 : decode issued a register write
//   i_chk_addr1/2, o_busy1/2              : hazard check for decode sources
//   o_wr, o_rd_addr, o_rd                 : registered register-file write
//   STARVE_MAX (1..15)                    : denied ALU cycles before ALU is forced
module rv32i_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR_W-1:0] i_alu_rd_addr,
    input  logic [XLEN-1:0]       i_alu_rd,
    input  logic                  i_mem_valid,
    output logic                  o_mem_ready,
    input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
    input  logic [XLEN-1:0]       i_mem_rd,
    input  logic                  i_issue,
    input  logic [REG_ADDR_W-1:0] i_issue_addr,
    input  logic [REG_ADDR_W-1:0] i_chk_addr1,
    input  logic [REG_ADDR_W-1:0] i_chk_addr2,
    output logic                  o_busy1,
    output logic                  o_busy2,
    output logic                  o_wr,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [XLEN-1:0]       o_rd
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q;
    logic                force_alu;
    logic                alu_acc;
    logic                mem_acc;
    wb_req_t             sel;

    // Loads win by default; once the ALU has been refused STARVE_MAX cycles
    // in a row it takes the port. Mem is only held off when the ALU is
    // actually requesting, so a stale limit never stalls a lone load.
    always_comb begin
        force_alu   = (starve_q == STARVE_LIM);
        o_alu_ready = !i_rst && (!i_mem_valid || force_alu);
        o_mem_ready = !i_rst && !(force_alu && i_alu_valid);
        alu_acc     = i_alu_valid && o_alu_ready;
        mem_acc     = i_mem_valid && o_mem_ready;
        sel         = mem_acc ? wb_req_t'{addr: i_mem_rd_addr, data: i_mem_rd}
                              : wb_req_t'{addr: i_alu_rd_addr, data: i_alu_rd};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_q  <= '0;
            o_wr      <= 1'b0;
            o_rd_addr <= '0;
            o_rd      <= '0;
        end else begin
            starve_q <= (i_alu_valid && !alu_acc) ? starve_q + STARVE_W'(1) : '0;
            o_wr     <= (alu_acc || mem_acc) && !is_x0(sel.addr);
            if (alu_acc || mem_acc) begin
                o_rd_addr <= sel.addr;
                o_rd      <= sel.data;
            end
        end
    end

    rv32i_wb_scoreboard u_scoreboard (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_issue      (i_issue),
        .i_issue_addr (i_issue_addr),
        .i_wr         (o_wr),
        .i_wr_addr    (o_rd_addr),
        .i_chk_addr1  (i_chk_addr1),
        .i_chk_addr2  (i_chk_addr2),
        .o_busy1      (o_busy1),
        .o_busy2      (o_busy2)
    );

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// tb_rv32i_wb_arbiter
//   Directed, table-driven bench for rv32i_wb_arbiter (STARVE_MAX = 3).
//   Each vector is one clock cycle: inputs, expected combinational outputs
//   in that cycle, expected registered write after the closing edge.
module tb_rv32i_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_alu_valid, o_alu_ready;
    logic [4:0]  i_alu_rd_addr;
    logic [31:0] i_alu_rd;
    logic        i_mem_valid, o_mem_ready;
    logic [4:0]  i_mem_rd_addr;
    logic [31:0] i_mem_rd;
    logic        i_issue;
    logic [4:0]  i_issue_addr, i_chk_addr1, i_chk_addr2;
    logic        o_busy1, o_busy2, o_wr;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    rv32i_wb_arbiter #(.STARVE_MAX(3)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_alu_valid   (i_alu_valid),
        .o_alu_ready   (o_alu_ready),
        .i_alu_rd_addr (i_alu_rd_addr),
        .i_alu_rd      (i_alu_rd),
        .i_mem_valid   (i_mem_valid),
        .o_mem_ready   (o_mem_ready),
        .i_mem_rd_addr (i_mem_rd_addr),
        .i_mem_rd      (i_mem_rd),
        .i_issue       (i_issue),
        .i_issue_addr  (i_issue_addr),
        .i_chk_addr1   (i_chk_addr1),
        .i_chk_addr2   (i_chk_addr2),
        .o_busy1       (o_busy1),
        .o_busy2       (o_busy2),
        .o_wr          (o_wr),
        .o_rd_addr     (o_rd_addr),
        .o_rd          (o_rd)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        e_ar;
        logic        e_mr;
        logic        e_b1;
        logic        e_b2;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic iss, input logic [4:0] ia,
                         input logic [4:0] c1, input logic [4:0] c2);
        i_alu_valid   = av;
        i_alu_rd_addr = aa;
        i_alu_rd      = ad;
        i_mem_valid   = mv;
        i_mem_rd_addr = ma;
        i_mem_rd      = md;
        i_issue       = iss;
        i_issue_addr  = ia;
        i_chk_addr1   = c1;
        i_chk_addr2   = c2;
    endtask

    // Drive inputs just after an edge, check combinational outputs mid-cycle,
    // then check the registered write 1 time unit after the closing edge.
    task automatic run_vec(input vec_t v, input int idx);
        drive(v.av, v.aa, v.ad, v.mv, v.ma, v.md, v.iss, v.ia, v.c1, v.c2);
        #3;
        check($sformatf("v%0d alu_ready", idx), 32'(o_alu_ready), 32'(v.e_ar));
        check($sformatf("v%0d mem_ready", idx), 32'(o_mem_ready), 32'(v.e_mr));
        check($sformatf("v%0d busy1", idx), 32'(o_busy1), 32'(v.e_b1));
        check($sformatf("v%0d busy2", idx), 32'(o_busy2), 32'(v.e_b2));
        @(posedge i_clk);
        #1;
        check($sformatf("v%0d wr", idx), 32'(o_wr), 32'(v.e_wr));
        if (v.e_wr) begin
            check($sformatf("v%0d rd_addr", idx), 32'(o_rd_addr), 32'(v.e_addr));
            check($sformatf("v%0d rd", idx), o_rd, v.e_data);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic iss, input logic [4:0] ia,
                                input logic [4:0] c1, input logic [4:0] c2,
                                input logic e_ar, input logic e_mr,
                                input logic e_b1, input logic e_b2,
                                input logic e_wr, input logic [4:0] e_addr,
                                input logic [31:0] e_data);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.iss = iss; v.ia = ia; v.c1 = c1; v.c2 = c2;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_b1 = e_b1; v.e_b2 = e_b2;
        v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
        return v;
    endfunction

    initial begin
        //               av aa  ad            mv ma  md            is ia c1 c2  ar mr b1 b2 wr addr data
        // ALU-only write
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 5, 0,  1, 1, 0, 0, 1, 5, 32'hDEADBEEF));
        // issue x7, then it reads busy, load writes x7, bypass in write cycle
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 7, 7, 5,  1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 7, 0,  1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 7, 32'h12345678, 0, 0, 7, 0,  0, 1, 1, 0, 1, 7, 32'h12345678));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 7, 7,  1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 7, 0,  1, 1, 0, 0, 0, 0, 0));
        // x0: issue ignored, load to x0 accepted but not written
        vecs.push_back(mk(0, 0, 0,            1, 0, 32'hFFFF0000, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
        // set/clear race on x9
        vecs.push_back(mk(0, 0, 0,            1, 9, 32'h00000099, 0, 0, 9, 0,  0, 1, 0, 0, 1, 9, 32'h00000099));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 9, 9, 0,  1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 9, 7,  1, 1, 1, 0, 0, 0, 0));
        // contention: mem, mem, mem, forced ALU, mem
        vecs.push_back(mk(1, 1, 32'hAAAA0001, 1, 2, 32'h0000B000, 0, 0, 9, 1,  0, 1, 1, 0, 1, 2, 32'h0000B000));
        vecs.push_back(mk(1, 1, 32'hAAAA0001, 1, 2, 32'h0000B001, 0, 0, 9, 2,  0, 1, 1, 0, 1, 2, 32'h0000B001));
        vecs.push_back(mk(1, 1, 32'hAAAA0001, 1, 2, 32'h0000B002, 0, 0, 9, 0,  0, 1, 1, 0, 1, 2, 32'h0000B002));
        vecs.push_back(mk(1, 1, 32'hAAAA0001, 1, 2, 32'h0000B003, 0, 0, 9, 0,  1, 0, 1, 0, 1, 1, 32'hAAAA0001));
        vecs.push_back(mk(1, 1, 32'hAAAA0002, 1, 2, 32'h0000B004, 0, 0, 9, 0,  0, 1, 1, 0, 1, 2, 32'h0000B004));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 9, 0,  1, 1, 1, 0, 0, 0, 0));

        // Reset: readies low during reset, registered outputs cleared.
        i_rst = 1'b1;
        drive(1, 4, 32'h11111111, 1, 6, 32'h22222222, 0, 0, 0, 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #3;
        check("rst alu_ready", 32'(o_alu_ready), 32'd0);
        check("rst mem_ready", 32'(o_mem_ready), 32'd0);
        @(posedge i_clk);
        #1;
        check("rst wr", 32'(o_wr), 32'd0);
        check("rst rd_addr", 32'(o_rd_addr), 32'd0);
        check("rst rd", o_rd, 32'd0);
        i_rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset mid-operation: build up starvation, accept load to x3 and
        // issue x3, then reset while the write is on the output.
        drive(1, 1, 32'h0, 1, 2, 32'h5, 0, 0, 0, 0);
        @(posedge i_clk); #1;
        drive(1, 1, 32'h0, 1, 3, 32'h33, 1, 3, 0, 0);
        #3;
        check("pre-rst alu_ready", 32'(o_alu_ready), 32'd0);
        check("pre-rst mem_ready", 32'(o_mem_ready), 32'd1);
        @(posedge i_clk); #1;
        check("pre-rst wr", 32'(o_wr), 32'd1);
        check("pre-rst rd_addr", 32'(o_rd_addr), 32'd3);
        i_rst = 1'b1;
        drive(1, 1, 32'h0, 1, 2, 32'h5, 0, 0, 9, 3);
        @(posedge i_clk); #1;
        check("mid-rst wr", 32'(o_wr), 32'd0);
        check("mid-rst rd_addr", 32'(o_rd_addr), 32'd0);
        check("mid-rst rd", o_rd, 32'd0);
        check("mid-rst busy9", 32'(o_busy1), 32'd0);
        check("mid-rst busy3", 32'(o_busy2), 32'd0);
        i_rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 3);
        @(posedge i_clk); #1;
        check("post-rst wr", 32'(o_wr), 32'd0);
        check("post-rst busy9", 32'(o_busy1), 32'd0);
        check("post-rst busy3", 32'(o_busy2), 32'd0);

        // Starve counter cleared by reset: ALU forced only on the 4th cycle.
        for (int unsigned c = 0; c < 4; c++) begin
            drive(1, 1, 32'hC0DE0000, 1, 2, 32'h0000D000 + 32'(c), 0, 0, 0, 0);
            #3;
            check($sformatf("post-rst c%0d alu_ready", c), 32'(o_alu_ready), (c == 3) ? 32'd1 : 32'd0);
            check($sformatf("post-rst c%0d mem_ready", c), 32'(o_mem_ready), (c == 3) ? 32'd0 : 32'd1);
            @(posedge i_clk); #1;
            check($sformatf("post-rst c%0d rd_addr", c), 32'(o_rd_addr), (c == 3) ? 32'd1 : 32'd2);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge i_clk); #1;
        check("idle wr", 32'(o_wr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
